// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// overflow/underflow pulses, synchronous flush and optional first-word-fall-through.

package fifo_sync_param_pkg;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 8,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 2,
    localparam int ADDR_WIDTH = log2_ceil(MEM_DEPTH),
    localparam int CNT_WIDTH  = log2_ceil(MEM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
        if (ptr == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign w_full   = (r_count == CNT_WIDTH'(MEM_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd & ~w_empty;
    assign w_wr_acc = wr & (~w_full | w_rd_acc);

    // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr & ~w_wr_acc;
            r_underflow <= rd & ~w_rd_acc;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; stale words are never exposed as valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !clr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented continuously; rd acknowledges and pops it.
            assign dout       = r_mem[r_rd_ptr];
            assign dout_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_dout_valid;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else if (clr) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_WIDTH'(AFULL_TH));
    assign almost_empty = (r_count <= CNT_WIDTH'(AEMPTY_TH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives three FIFO configurations (std depth 8, std depth 5, FWFT depth 8) with one
// shared stimulus and compares each against a queue-based reference model.

module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        wr;
    logic        rd;
    logic [31:0] din;

    always #5 clk = ~clk;

    logic [31:0] dout_a, dout_b, dout_c;
    logic        dv_a, dv_b, dv_c;
    logic        full_a, full_b, full_c;
    logic        empty_a, empty_b, empty_c;
    logic        af_a, af_b, af_c;
    logic        ae_a, ae_b, ae_c;
    logic [3:0]  cnt_a, cnt_c;
    logic [2:0]  cnt_b;
    logic        ovf_a, ovf_b, ovf_c;
    logic        unf_a, unf_b, unf_c;

    fifo_sync_param #(
        .DATA_WIDTH(32), .MEM_DEPTH(8), .FWFT(1'b0), .AFULL_TH(6), .AEMPTY_TH(2)
    ) u_std8 (
        .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .din(din), .rd(rd),
        .dout(dout_a), .dout_valid(dv_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    fifo_sync_param #(
        .DATA_WIDTH(32), .MEM_DEPTH(5), .FWFT(1'b0), .AFULL_TH(4), .AEMPTY_TH(1)
    ) u_std5 (
        .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .din(din), .rd(rd),
        .dout(dout_b), .dout_valid(dv_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    fifo_sync_param #(
        .DATA_WIDTH(32), .MEM_DEPTH(8), .FWFT(1'b1), .AFULL_TH(6), .AEMPTY_TH(2)
    ) u_fwft8 (
        .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .din(din), .rd(rd),
        .dout(dout_c), .dout_valid(dv_c), .full(full_c), .empty(empty_c),
        .almost_full(af_c), .almost_empty(ae_c), .count(cnt_c),
        .overflow(ovf_c), .underflow(unf_c)
    );

    typedef struct packed {
        logic [31:0] dout;
        logic        dv;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } obs_t;

    obs_t obs [3];

    always_comb begin
        obs[0] = {dout_a, dv_a, full_a, empty_a, af_a, ae_a, cnt_a, ovf_a, unf_a};
        obs[1] = {dout_b, dv_b, full_b, empty_b, af_b, ae_b, {1'b0, cnt_b}, ovf_b, unf_b};
        obs[2] = {dout_c, dv_c, full_c, empty_c, af_c, ae_c, cnt_c, ovf_c, unf_c};
    end

    function automatic int dep(input int k);
        return (k == 1) ? 5 : 8;
    endfunction

    function automatic int af_th(input int k);
        return (k == 1) ? 4 : 6;
    endfunction

    function automatic int ae_th(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic bit is_fwft(input int k);
        return (k == 2);
    endfunction

    // Reference model: a queue of stored words plus the registered read/error outputs.
    logic [31:0] mq [3][$];
    logic [31:0] m_dout [3];
    bit          m_dv   [3];
    bit          m_ovf  [3];
    bit          m_unf  [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_dout[k] = '0;
            m_dv[k]   = 1'b0;
            m_ovf[k]  = 1'b0;
            m_unf[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                mq[k].delete();
                m_dv[k]  = 1'b0;
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end else begin
                bit rd_ok;
                bit wr_ok;
                rd_ok = rd && (mq[k].size() > 0);
                wr_ok = wr && ((mq[k].size() < dep(k)) || rd_ok);
                m_ovf[k] = wr && !wr_ok;
                m_unf[k] = rd && !rd_ok;
                m_dv[k]  = rd_ok;
                if (rd_ok) begin
                    m_dout[k] = mq[k].pop_front();
                end
                if (wr_ok) begin
                    mq[k].push_back(din);
                end
            end
        end
    endtask

    task automatic compare_all(input bool_check_dout_after_reset = 1'b1);
        for (int k = 0; k < 3; k++) begin
            string p;
            int    sz;
            p  = $sformatf("i%0d", k);
            sz = mq[k].size();
            check({p, ".count"}, 64'(obs[k].cnt), 64'(sz));
            check({p, ".full"},  64'(obs[k].full),  64'(sz == dep(k)));
            check({p, ".empty"}, 64'(obs[k].empty), 64'(sz == 0));
            check({p, ".afull"}, 64'(obs[k].af),    64'(sz >= af_th(k)));
            check({p, ".aempty"}, 64'(obs[k].ae),   64'(sz <= ae_th(k)));
            check({p, ".ovf"},   64'(obs[k].ovf),   64'(m_ovf[k]));
            check({p, ".unf"},   64'(obs[k].unf),   64'(m_unf[k]));
            if (is_fwft(k)) begin
                check({p, ".dvalid"}, 64'(obs[k].dv), 64'(sz > 0));
                if (sz > 0) begin
                    check({p, ".dout"}, 64'(obs[k].dout), 64'(mq[k][0]));
                end
            end else begin
                check({p, ".dvalid"}, 64'(obs[k].dv), 64'(m_dv[k]));
                if (bool_check_dout_after_reset) begin
                    check({p, ".dout"}, 64'(obs[k].dout), 64'(m_dout[k]));
                end
            end
        end
    endtask

    // Called at a falling edge: apply inputs, let the rising edge happen, check at the next fall.
    task automatic step(input bit w, input bit r, input logic [31:0] d, input bit c = 1'b0);
        wr  = w;
        rd  = r;
        din = d;
        clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset_pulse();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        clr  = 1'b0;
        wr   = 1'b0;
        rd   = 1'b0;
        din  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rstn = 1'b1;

        // Fill past full, drain past empty.
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 32'(i));
        for (int i = 0; i < 9; i++)  step(1'b0, 1'b1, '0);

        // Full FIFO with simultaneous read and write, then drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 32'(100 + i));
        for (int i = 0; i < 9; i++)  step(1'b0, 1'b1, '0);

        // Read and write together on an empty FIFO.
        step(1'b1, 1'b1, 32'd5);
        step(1'b0, 1'b1, '0);

        // Threshold crossings.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'(200 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

        // Flush has priority over simultaneous read and write.
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(300 + i));
        step(1'b1, 1'b1, 32'hDEAD, 1'b1);
        step(1'b0, 1'b0, '0);

        // Long interleaved stream to wrap the pointers several times.
        for (int i = 0; i < 23; i++) begin
            step(1'b1, 1'b0, 32'(400 + i));
            step(1'b0, 1'b1, '0);
        end

        // Word written into an empty FIFO, left idle, then popped.
        step(1'b1, 1'b0, 32'hA5);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);

        // Asynchronous reset with data in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(500 + i));
        async_reset_pulse();
        step(1'b1, 1'b0, 32'h77);
        step(1'b0, 1'b1, '0);

        // Randomized traffic in phases with different read/write biases.
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            int pr;
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                     $urandom(), ($urandom_range(0, 63) == 0));
            end
            if (ph == 3) begin
                async_reset_pulse();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
